// File: rtl/dmem_dual_port_ctrl_if.sv
// Core-side request/response bus of the shared data-memory controller.
//   master : the requesting cores (drive req_*, observe ack/resp)
//   slave  : dmem_dual_port_ctrl
// Per-core fields are packed; core i lives at [32i+:32] / [4i+:4] / [i].
interface dmem_dual_port_ctrl_if #(
  parameter int NCORES     = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [NCORES-1:0]            req_valid;
  logic [NCORES*ADDR_WIDTH-1:0] req_addr_packed;
  logic [NCORES*4-1:0]          req_wstrb_packed;
  logic [NCORES*32-1:0]         req_wdata_packed;
  logic [NCORES-1:0]            req_ack;
  logic [NCORES-1:0]            resp_valid;
  logic [NCORES*32-1:0]         resp_rdata_packed;

  modport master (
    output req_valid, req_addr_packed, req_wstrb_packed, req_wdata_packed,
    input  req_ack, resp_valid, resp_rdata_packed
  );

  modport slave (
    input  req_valid, req_addr_packed, req_wstrb_packed, req_wdata_packed,
    output req_ack, resp_valid, resp_rdata_packed
  );
endinterface

// File: rtl/dmem_dual_port_ctrl.sv
// dmem_dual_port_ctrl
//   Sits behind dual_issue_arbiter. Owns the round-robin pointer, steers the
//   two arbiter grants onto the A/B ports of a true-dual-port BRAM, acks the
//   granted cores in the same cycle and returns read data one cycle later.
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   core                      per-core request/response bus (slave modport)
//   arb_rr_ptr_o              round-robin pointer to the arbiter
//   arb_valid/sel_{a,b}_i     grants from the arbiter
//   mem_{en,we,addr,wdata}_*  BRAM port controls, mem_rdata_*_i read data
//   perf_*_o                  event counters
// Optional feature: define DMEM_PERF_CNT_EN to build the saturating perf
// counters; otherwise perf_* are tied to 0 and no counter flops exist.
module dmem_dual_port_ctrl #(
  parameter int NCORES     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DMEM_WORDS = 4096,
  localparam int PW = $clog2(NCORES),
  localparam int AW = $clog2(DMEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dmem_dual_port_ctrl_if.slave  core,
  output logic [PW-1:0]         arb_rr_ptr_o,
  input  logic                  arb_valid_a_i,
  input  logic                  arb_valid_b_i,
  input  logic [PW-1:0]         arb_sel_a_i,
  input  logic [PW-1:0]         arb_sel_b_i,
  output logic                  mem_en_a_o,
  output logic                  mem_en_b_o,
  output logic [3:0]            mem_we_a_o,
  output logic [3:0]            mem_we_b_o,
  output logic [AW-1:0]         mem_addr_a_o,
  output logic [AW-1:0]         mem_addr_b_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_a_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_b_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_b_i,
  output logic [31:0]           perf_dual_o,
  output logic [31:0]           perf_single_o,
  output logic [31:0]           perf_conflict_o
);
  // Lanes are padded to a power of two so an out-of-range select from the
  // arbiter lands on an always-idle lane instead of indexing past the array.
  localparam int NP = 1 << PW;

  logic [NP-1:0]         req_v;
  logic [AW-1:0]         waddr_u [NP];
  logic [3:0]            wstrb_u [NP];
  logic [DATA_WIDTH-1:0] wdata_u [NP];
  logic                  unused_addr_bits;

  assign req_v = NP'(core.req_valid);
  // Byte-offset and bits above the BRAM depth are deliberately dropped (aliasing).
  assign unused_addr_bits = ^core.req_addr_packed;

  for (genvar i = 0; i < NP; i++) begin : g_lane
    if (i < NCORES) begin : g_real
      assign waddr_u[i] = core.req_addr_packed[i*ADDR_WIDTH+2 +: AW];
      assign wstrb_u[i] = core.req_wstrb_packed[i*4 +: 4];
      assign wdata_u[i] = core.req_wdata_packed[i*32 +: 32];
    end else begin : g_pad
      assign waddr_u[i] = '0;
      assign wstrb_u[i] = '0;
      assign wdata_u[i] = '0;
    end
  end

  // A grant only takes effect for a core that is actually requesting; B is
  // dropped if the arbiter ever hands it the same core as A.
  logic gnt_a, gnt_b;
  assign gnt_a = arb_valid_a_i && req_v[arb_sel_a_i];
  assign gnt_b = arb_valid_b_i && req_v[arb_sel_b_i] &&
                 !(arb_valid_a_i && (arb_sel_b_i == arb_sel_a_i));

  logic [NP-1:0] ack;
  always_comb begin
    ack = '0;
    if (gnt_a) ack[arb_sel_a_i] = 1'b1;
    if (gnt_b) ack[arb_sel_b_i] = 1'b1;
  end
  assign core.req_ack = ack[NCORES-1:0];

  assign mem_en_a_o    = gnt_a;
  assign mem_we_a_o    = gnt_a ? wstrb_u[arb_sel_a_i] : '0;
  assign mem_addr_a_o  = gnt_a ? waddr_u[arb_sel_a_i] : '0;
  assign mem_wdata_a_o = gnt_a ? wdata_u[arb_sel_a_i] : '0;
  assign mem_en_b_o    = gnt_b;
  assign mem_we_b_o    = gnt_b ? wstrb_u[arb_sel_b_i] : '0;
  assign mem_addr_b_o  = gnt_b ? waddr_u[arb_sel_b_i] : '0;
  assign mem_wdata_b_o = gnt_b ? wdata_u[arb_sel_b_i] : '0;

  // Read tags: one per BRAM port; the port is implied by which tag it is.
  logic          tag_vld_a, tag_vld_b;
  logic [PW-1:0] tag_core_a, tag_core_b, rr_ptr;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] s);
    return (s == PW'(NCORES - 1)) ? '0 : s + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_vld_a  <= 1'b0;
      tag_vld_b  <= 1'b0;
      tag_core_a <= '0;
      tag_core_b <= '0;
      rr_ptr     <= '0;
    end else begin
      tag_vld_a  <= gnt_a && (wstrb_u[arb_sel_a_i] == 4'b0);
      tag_vld_b  <= gnt_b && (wstrb_u[arb_sel_b_i] == 4'b0);
      tag_core_a <= arb_sel_a_i;
      tag_core_b <= arb_sel_b_i;
      if (arb_valid_b_i)      rr_ptr <= rr_next(arb_sel_b_i);
      else if (arb_valid_a_i) rr_ptr <= rr_next(arb_sel_a_i);
    end
  end
  assign arb_rr_ptr_o = rr_ptr;

  logic [NP-1:0]        resp_v;
  logic [NCORES*32-1:0] resp_rd;
  always_comb begin
    resp_v  = '0;
    resp_rd = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (tag_vld_a && (tag_core_a == PW'(i))) begin
        resp_v[i]          = 1'b1;
        resp_rd[i*32 +: 32] = mem_rdata_a_i;
      end
      if (tag_vld_b && (tag_core_b == PW'(i))) begin
        resp_v[i]          = 1'b1;
        resp_rd[i*32 +: 32] = mem_rdata_b_i;
      end
    end
  end
  assign core.resp_valid        = resp_v[NCORES-1:0];
  assign core.resp_rdata_packed = resp_rd;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] cnt_dual, cnt_single, cnt_conflict;
  logic        conflict;
  assign conflict = ($countones(core.req_valid) >= 2) && !arb_valid_b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_dual     <= '0;
      cnt_single   <= '0;
      cnt_conflict <= '0;
    end else begin
      if (gnt_a && gnt_b && (cnt_dual != '1))    cnt_dual     <= cnt_dual + 1'b1;
      if (gnt_a && !gnt_b && (cnt_single != '1)) cnt_single   <= cnt_single + 1'b1;
      if (conflict && (cnt_conflict != '1))      cnt_conflict <= cnt_conflict + 1'b1;
    end
  end
  assign perf_dual_o     = cnt_dual;
  assign perf_single_o   = cnt_single;
  assign perf_conflict_o = cnt_conflict;
`else
  assign perf_dual_o     = '0;
  assign perf_single_o   = '0;
  assign perf_conflict_o = '0;
`endif
endmodule
